ra_2r1w_port_arb: RTL and testbench

- Arbiter/sequencer in front of the ra_2r1w_32x32_sdr register array.
- Shares the array's two read ports among NREQ read requesters using round-robin.
- Passes one write requester straight to write port 0 and drives the array strobe.
- Forwards write data when a read and a write hit the same address in the same cycle.

---
 rtl/ra_2r1w_pkg.sv | 16 +
 rtl/ra_2r1w_port_arb_rr_pick2.sv | 39 +++
 rtl/ra_2r1w_port_arb.sv | 134 +++++++++++++
 tb/tb_ra_2r1w_port_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ra_2r1w_pkg.sv
// Shared defaults and types for the ra_2r1w register-array front end.
package ra_2r1w_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    typedef logic [0:AW-1] adr_t;
    typedef logic [0:DW-1] dat_t;

    // Increment a requester index with wrap at n.
    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/ra_2r1w_port_arb_rr_pick2.sv
// Combinational round-robin picker returning up to two winners, scanning from ptr.
module rr_pick2 #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx0,
    output logic            v0,
    output logic [IDW-1:0]  idx1,
    output logic            v1
);

    always_comb begin
        gnt  = '0;
        idx0 = '0;
        idx1 = '0;
        v0   = 1'b0;
        v1   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned j;
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (req[j]) begin
                if (!v0) begin
                    v0     = 1'b1;
                    idx0   = IDW'(j);
                    gnt[j] = 1'b1;
                end else if (!v1) begin
                    v1     = 1'b1;
                    idx1   = IDW'(j);
                    gnt[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ra_2r1w_port_arb.sv
// Shares the array's two read ports among NREQ requesters, passes the writer through
// to write port 0, and forwards write data to same-cycle reads of the same address.
module ra_2r1w_port_arb #(
    parameter int unsigned NREQ = ra_2r1w_pkg::NREQ,
    parameter int unsigned AW   = ra_2r1w_pkg::AW,
    parameter int unsigned DW   = ra_2r1w_pkg::DW,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    rq_vld,
    input  logic [NREQ*AW-1:0] rq_adr,
    output logic [NREQ-1:0]    rq_rdy,
    output logic               rs_vld_0,
    output logic               rs_vld_1,
    output logic [IDW-1:0]     rs_id_0,
    output logic [IDW-1:0]     rs_id_1,
    output logic [0:DW-1]      rs_dat_0,
    output logic [0:DW-1]      rs_dat_1,
    input  logic               wr_req,
    input  logic [0:AW-1]      wr_adr,
    input  logic [0:DW-1]      wr_dat,
    output logic               wr_ack,
    output logic               strobe,
    output logic               rd_enb_0,
    output logic               rd_enb_1,
    output logic [0:AW-1]      rd_adr_0,
    output logic [0:AW-1]      rd_adr_1,
    input  logic [0:DW-1]      rd_dat_0,
    input  logic [0:DW-1]      rd_dat_1,
    output logic               wr_enb_0,
    output logic [0:AW-1]      wr_adr_0,
    output logic [0:DW-1]      wr_dat_0
);
    import ra_2r1w_pkg::*;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  idx0, idx1, last;
    logic            v0, v1;

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            vld0_q, vld0_d, vld1_q, vld1_d;
    logic [IDW-1:0]  id0_q, id0_d, id1_q, id1_d;
    logic            fwd0_q, fwd0_d, fwd1_q, fwd1_d;
    logic [0:DW-1]   wdat_q, wdat_d;

    rr_pick2 #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req  (rq_vld),
        .ptr  (ptr_q),
        .gnt  (gnt),
        .idx0 (idx0),
        .v0   (v0),
        .idx1 (idx1),
        .v1   (v1)
    );

    // Every combinational output is held at zero while reset is asserted.
    always_comb begin
        rq_rdy   = '0;
        rd_enb_0 = 1'b0;
        rd_enb_1 = 1'b0;
        rd_adr_0 = '0;
        rd_adr_1 = '0;
        wr_enb_0 = 1'b0;
        wr_ack   = 1'b0;
        wr_adr_0 = '0;
        wr_dat_0 = '0;
        if (reset) begin
            rq_rdy   = gnt;
            rd_enb_0 = v0;
            rd_enb_1 = v1;
            if (v0) rd_adr_0 = rq_adr[idx0*AW +: AW];
            if (v1) rd_adr_1 = rq_adr[idx1*AW +: AW];
            wr_enb_0 = wr_req;
            wr_ack   = wr_req;
            wr_adr_0 = wr_adr;
            wr_dat_0 = wr_dat;
        end
    end

    assign strobe = rd_enb_0 | rd_enb_1 | wr_enb_0;

    always_comb begin
        last   = v1 ? idx1 : idx0;
        ptr_d  = ptr_q;
        if (rd_enb_0) ptr_d = IDW'(wrap_inc(int'(last), NREQ));
        vld0_d = rd_enb_0;
        vld1_d = rd_enb_1;
        id0_d  = rd_enb_0 ? idx0 : '0;
        id1_d  = rd_enb_1 ? idx1 : '0;
        fwd0_d = rd_enb_0 && wr_enb_0 && (wr_adr_0 == rd_adr_0);
        fwd1_d = rd_enb_1 && wr_enb_0 && (wr_adr_0 == rd_adr_1);
        wdat_d = wr_enb_0 ? wr_dat_0 : wdat_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q  <= '0;
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
            id0_q  <= '0;
            id1_q  <= '0;
            fwd0_q <= 1'b0;
            fwd1_q <= 1'b0;
            wdat_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            vld0_q <= vld0_d;
            vld1_q <= vld1_d;
            id0_q  <= id0_d;
            id1_q  <= id1_d;
            fwd0_q <= fwd0_d;
            fwd1_q <= fwd1_d;
            wdat_q <= wdat_d;
        end
    end

    // Array data arrives one cycle after enable; a forwarded lane uses the registered write data.
    always_comb begin
        rs_dat_0 = '0;
        rs_dat_1 = '0;
        if (reset && vld0_q) rs_dat_0 = fwd0_q ? wdat_q : rd_dat_0;
        if (reset && vld1_q) rs_dat_1 = fwd1_q ? wdat_q : rd_dat_1;
    end

    assign rs_vld_0 = vld0_q;
    assign rs_vld_1 = vld1_q;
    assign rs_id_0  = id0_q;
    assign rs_id_1  = id1_q;

endmodule

// File: tb/tb_ra_2r1w_port_arb.sv
// Directed bench for ra_2r1w_port_arb with a behavioural 32x32 array behind it.
module tb_ra_2r1w_port_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned IDW  = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    rq_vld;
    logic [NREQ*AW-1:0] rq_adr;
    logic [NREQ-1:0]    rq_rdy;
    logic               rs_vld_0, rs_vld_1;
    logic [IDW-1:0]     rs_id_0, rs_id_1;
    logic [0:DW-1]      rs_dat_0, rs_dat_1;
    logic               wr_req;
    logic [0:AW-1]      wr_adr;
    logic [0:DW-1]      wr_dat;
    logic               wr_ack, strobe;
    logic               rd_enb_0, rd_enb_1;
    logic [0:AW-1]      rd_adr_0, rd_adr_1;
    logic [0:DW-1]      rd_dat_0, rd_dat_1;
    logic               wr_enb_0;
    logic [0:AW-1]      wr_adr_0;
    logic [0:DW-1]      wr_dat_0;

    logic [0:DW-1]      mem [32];
    logic               load;
    int                 total = 0;
    int                 bad   = 0;

    always #5 clk = ~clk;

    ra_2r1w_port_arb #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW),
        .IDW  (IDW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rq_vld   (rq_vld),
        .rq_adr   (rq_adr),
        .rq_rdy   (rq_rdy),
        .rs_vld_0 (rs_vld_0),
        .rs_vld_1 (rs_vld_1),
        .rs_id_0  (rs_id_0),
        .rs_id_1  (rs_id_1),
        .rs_dat_0 (rs_dat_0),
        .rs_dat_1 (rs_dat_1),
        .wr_req   (wr_req),
        .wr_adr   (wr_adr),
        .wr_dat   (wr_dat),
        .wr_ack   (wr_ack),
        .strobe   (strobe),
        .rd_enb_0 (rd_enb_0),
        .rd_enb_1 (rd_enb_1),
        .rd_adr_0 (rd_adr_0),
        .rd_adr_1 (rd_adr_1),
        .rd_dat_0 (rd_dat_0),
        .rd_dat_1 (rd_dat_1),
        .wr_enb_0 (wr_enb_0),
        .wr_adr_0 (wr_adr_0),
        .wr_dat_0 (wr_dat_0)
    );

    // Array model: read returns pre-write contents, data one cycle after enable.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (wr_enb_0) begin
            mem[wr_adr_0] <= wr_dat_0;
        end
        if (rd_enb_0) rd_dat_0 <= mem[rd_adr_0];
        if (rd_enb_1) rd_dat_1 <= mem[rd_adr_1];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] v, input logic [4:0] a0, input logic [4:0] a1,
                           input logic [4:0] a2, input logic [4:0] a3);
        rq_vld = v;
        rq_adr = {a3, a2, a1, a0};
    endtask

    initial begin
        int unsigned base;
        reset  = 1'b0;
        load   = 1'b1;
        wr_req = 1'b0;
        wr_adr = '0;
        wr_dat = '0;
        set_req(4'b0000, 0, 0, 0, 0);

        // Held in reset: outputs forced low even with requests present
        step();
        set_req(4'b1111, 1, 2, 3, 4);
        wr_req = 1'b1;
        #1;
        chk("rst_rq_rdy", 32'(rq_rdy), 0);
        chk("rst_strobe", 32'(strobe), 0);
        chk("rst_wr_ack", 32'(wr_ack), 0);
        chk("rst_rs_vld0", 32'(rs_vld_0), 0);
        step();
        load   = 1'b0;
        reset  = 1'b1;
        wr_req = 1'b0;
        set_req(4'b0000, 0, 0, 0, 0);
        #1;
        chk("idle_rq_rdy", 32'(rq_rdy), 0);
        chk("idle_strobe", 32'(strobe), 0);
        chk("idle_rd_enb0", 32'(rd_enb_0), 0);
        chk("idle_rs_vld0", 32'(rs_vld_0), 0);
        chk("idle_rs_vld1", 32'(rs_vld_1), 0);
        chk("idle_rs_dat0", rs_dat_0, 0);

        // Plain write
        wr_req = 1'b1;
        wr_adr = 5'd1;
        wr_dat = 32'h0000_AAAA;
        #1;
        chk("wr_enb0", 32'(wr_enb_0), 1);
        chk("wr_strobe", 32'(strobe), 1);
        chk("wr_ack", 32'(wr_ack), 1);
        chk("wr_adr0", 32'(wr_adr_0), 1);
        chk("wr_dat0", wr_dat_0, 32'h0000_AAAA);

        // Read it back via requester 0
        step();
        wr_req = 1'b0;
        set_req(4'b0001, 1, 0, 0, 0);
        #1;
        chk("rd0_rq_rdy", 32'(rq_rdy), 32'h1);
        chk("rd0_enb0", 32'(rd_enb_0), 1);
        chk("rd0_enb1", 32'(rd_enb_1), 0);
        chk("rd0_adr0", 32'(rd_adr_0), 1);
        chk("rd0_strobe", 32'(strobe), 1);

        // Pointer now 1: lone requester 3 lands on lane 0
        step();
        set_req(4'b1000, 0, 0, 0, 9);
        #1;
        chk("rd0_rs_vld0", 32'(rs_vld_0), 1);
        chk("rd0_rs_id0", 32'(rs_id_0), 0);
        chk("rd0_rs_dat0", rs_dat_0, 32'h0000_AAAA);
        chk("rd0_rs_vld1", 32'(rs_vld_1), 0);
        chk("r3_rq_rdy", 32'(rq_rdy), 32'h8);
        chk("r3_enb0", 32'(rd_enb_0), 1);
        chk("r3_adr0", 32'(rd_adr_0), 9);
        chk("r3_enb1", 32'(rd_enb_1), 0);

        step();
        set_req(4'b1111, 16, 17, 18, 19);
        #1;
        chk("r3_rs_id0", 32'(rs_id_0), 3);
        chk("r3_rs_dat0", rs_dat_0, 32'hA500_0009);
        chk("r3_rs_vld1", 32'(rs_vld_1), 0);

        // All four valid from pointer 0: {0,1},{2,3},{0,1},{2,3}
        for (int k = 0; k < 4; k++) begin
            base = (k % 2 == 1) ? 2 : 0;
            chk("all_rq_rdy", 32'(rq_rdy), (k % 2 == 1) ? 32'hC : 32'h3);
            chk("all_adr0", 32'(rd_adr_0), 16 + base);
            chk("all_adr1", 32'(rd_adr_1), 17 + base);
            step();
            #1;
            chk("all_vld0", 32'(rs_vld_0), 1);
            chk("all_vld1", 32'(rs_vld_1), 1);
            chk("all_id0", 32'(rs_id_0), base);
            chk("all_id1", 32'(rs_id_1), base + 1);
            chk("all_dat0", rs_dat_0, 32'hA500_0010 + base);
            chk("all_dat1", rs_dat_1, 32'hA500_0011 + base);
        end

        // Forward on lane 0 only; lane 1 reads a different address
        set_req(4'b1100, 0, 0, 8, 9);
        wr_req = 1'b1;
        wr_adr = 5'd8;
        wr_dat = 32'h0000_0008;
        #1;
        chk("fw_rq_rdy", 32'(rq_rdy), 32'hC);
        chk("fw_adr0", 32'(rd_adr_0), 8);
        chk("fw_adr1", 32'(rd_adr_1), 9);
        chk("fw_wr_enb", 32'(wr_enb_0), 1);

        // Both lanes read the address being written
        step();
        set_req(4'b0011, 8, 8, 0, 0);
        wr_dat = 32'h1234_5678;
        #1;
        chk("fw_id0", 32'(rs_id_0), 2);
        chk("fw_dat0", rs_dat_0, 32'h0000_0008);
        chk("fw_id1", 32'(rs_id_1), 3);
        chk("fw_dat1", rs_dat_1, 32'hA500_0009);
        chk("fw2_rq_rdy", 32'(rq_rdy), 32'h3);
        chk("fw2_adr1", 32'(rd_adr_1), 8);

        step();
        wr_req = 1'b0;
        set_req(4'b1111, 16, 17, 18, 19);
        #1;
        chk("fw2_dat0", rs_dat_0, 32'h1234_5678);
        chk("fw2_dat1", rs_dat_1, 32'h1234_5678);
        chk("fw2_id1", 32'(rs_id_1), 1);
        chk("p2_rq_rdy", 32'(rq_rdy), 32'hC);

        // Reset right after a two-lane grant
        step();
        chk("pre_rst_vld0", 32'(rs_vld_0), 1);
        chk("pre_rst_vld1", 32'(rs_vld_1), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_vld0", 32'(rs_vld_0), 0);
        chk("mid_rst_vld1", 32'(rs_vld_1), 0);
        chk("mid_rst_rq_rdy", 32'(rq_rdy), 0);
        chk("mid_rst_strobe", 32'(strobe), 0);
        chk("mid_rst_dat0", rs_dat_0, 0);
        step();
        reset = 1'b1;
        #1;
        chk("post_rst_rq_rdy", 32'(rq_rdy), 32'h3);
        chk("post_rst_vld0", 32'(rs_vld_0), 0);
        step();
        chk("post_rst_id0", 32'(rs_id_0), 0);
        chk("post_rst_id1", 32'(rs_id_1), 1);
        chk("post_rst_rs_vld0", 32'(rs_vld_0), 1);
        chk("post_rst_next", 32'(rq_rdy), 32'hC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
